// File: rtl/neuron_pkg.sv
// Shared widths and FSM state encodings for the neuron MAC datapath.
// Fixed-point formats: input Q2.9 sign-magnitude, weight Q1.1, result Q12.10.
package neuron_pkg;

   localparam int IN_W     = 12;
   localparam int W_W      = 3;
   localparam int IN_FRAC  = 9;
   localparam int W_FRAC   = 1;
   localparam int PMAG_W   = 13;
   localparam int OUT_W    = 23;
   localparam int OUT_FRAC = 10;

   localparam int OUT_MAG_W = OUT_W - 1;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t RUN   = 2'd1;
   localparam state_t DRAIN = 2'd2;
   localparam state_t DONE  = 2'd3;

endpackage

// File: rtl/neuron_sm_mul_stage.sv
// Registered sign-magnitude multiplier producing a signed two's-complement product.
// Idle cycles and zero-magnitude products both register +0.
module neuron_sm_mul_stage
   import neuron_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [IN_W-1:0]          in_data,
   input  logic [W_W-1:0]           in_weight,
   output logic signed [PMAG_W:0]   product
);

   logic [PMAG_W-1:0] mag;
   logic              sign;

   // NOTE: combinational blocks use blocking assignments and assign every output on every path, so no latch is inferred.
   always_comb begin
      mag  = PMAG_W'(in_data[IN_W-2:0]) * PMAG_W'(in_weight[W_W-2:0]);
      sign = in_data[IN_W-1] ^ in_weight[W_W-1];
   end

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         product <= '0;
      end else if (sign && (mag != '0)) begin
         product <= -$signed({1'b0, mag});
      end else begin
         product <= $signed({1'b0, mag});
      end
   end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Streams N_INPUTS (input, weight) pairs through one multiplier stage and accumulates
// the products into a sign-magnitude neuron pre-activation result.
module neuron_mac_sequencer
   import neuron_pkg::*;
#(
   parameter int N_INPUTS = 4,
   parameter int ACC_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_W-1:0]      in_data,
   input  logic [W_W-1:0]       in_weight,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_W-1:0]     out_result
);

   localparam int CNT_W = $clog2(N_INPUTS + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_INPUTS - 1);

   state_t                    state;
   logic [CNT_W-1:0]          beat_cnt;
   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   acc_next;
   logic [ACC_W-1:0]          acc_abs;
   logic signed [PMAG_W:0]    product;
   logic                      beat;

   assign busy      = (state != IDLE);
   assign in_ready  = (state == RUN);
   assign out_valid = (state == DONE);
   assign beat      = in_valid && in_ready;

   neuron_sm_mul_stage u_mul (
      .clk       (clk),
      .rst       (rst),
      .en        (beat),
      .in_data   (in_data),
      .in_weight (in_weight),
      .product   (product)
   );

   // The result is taken from acc_next so the product landing in the DRAIN cycle is included.
   always_comb begin
      acc_next = acc + ACC_W'(product);
      acc_abs  = acc_next[ACC_W-1] ? ACC_W'(-acc_next) : ACC_W'(acc_next);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         beat_cnt   <= '0;
         acc        <= '0;
         out_result <= '0;
      end else begin
         acc <= acc_next;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= RUN;
                  beat_cnt <= '0;
                  acc      <= '0;
               end
            end
            RUN: begin
               if (beat) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (beat_cnt == LAST_BEAT) state <= DRAIN;
               end
            end
            DRAIN: begin
               state      <= DONE;
               out_result <= {acc_next[ACC_W-1], OUT_MAG_W'(acc_abs)};
            end
            default: begin
               if (out_ready) state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed self-checking bench for neuron_mac_sequencer with hand-computed results.
module tb_neuron_mac_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        busy;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_data;
   logic [2:0]  in_weight;
   logic        out_valid;
   logic        out_ready;
   logic [22:0] out_result;

   int n_checks = 0;
   int n_errors = 0;

   logic [11:0] td [4];
   logic [2:0]  tw [4];
   logic [22:0] held;

   always #5 clk = ~clk;

   neuron_mac_sequencer #(.N_INPUTS(4), .ACC_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_weight  (in_weight),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vec(input logic [11:0] d0, d1, d2, d3, input logic [2:0] w0, w1, w2, w3);
      td[0] = d0; td[1] = d1; td[2] = d2; td[3] = d3;
      tw[0] = w0; tw[1] = w1; tw[2] = w2; tw[3] = w3;
   endtask

   // Runs one evaluation up to DONE and checks the 2-cycle result latency.
   task automatic run_vec(input string tag, input bit gaps, input logic [22:0] exp);
      start = 1'b1;
      step();
      start = 1'b0;
      check({tag, " in_ready_run"}, 32'(in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         in_valid  = 1'b1;
         in_data   = td[i];
         in_weight = tw[i];
         step();
         if (gaps && i < 3) begin
            in_valid  = 1'b0;
            in_data   = 12'hFFF;
            in_weight = 3'b011;
            check({tag, " in_ready_gap"}, 32'(in_ready), 32'd1);
            step();
         end
      end
      in_valid = 1'b0;
      check({tag, " out_valid_drain"}, 32'(out_valid), 32'd0);
      check({tag, " in_ready_drain"}, 32'(in_ready), 32'd0);
      step();
      check({tag, " out_valid_done"}, 32'(out_valid), 32'd1);
      check({tag, " result"}, 32'(out_result), 32'(exp));
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, " busy_after_ack"}, 32'(busy), 32'd0);
      check({tag, " out_valid_after_ack"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_weight = '0; out_ready = 1'b0;
      step();
      step();
      check("reset busy", 32'(busy), 32'd0);
      check("reset in_ready", 32'(in_ready), 32'd0);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset out_result", 32'(out_result), 32'd0);
      rst = 1'b0;
      step();

      set_vec(12'h200, 12'h200, 12'h200, 12'h200, 3'b010, 3'b010, 3'b010, 3'b010);
      run_vec("t1", 1'b0, 23'h001000);
      handshake("t1");

      set_vec(12'h200, 12'h200, 12'h100, 12'h900, 3'b010, 3'b110, 3'b011, 3'b001);
      run_vec("t2", 1'b0, 23'h000200);
      handshake("t2");

      set_vec(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 3'b011, 3'b011, 3'b011, 3'b011);
      run_vec("t3", 1'b0, 23'h405FF4);
      handshake("t3");

      set_vec(12'h200, 12'h200, 12'h200, 12'h200, 3'b010, 3'b010, 3'b010, 3'b010);
      run_vec("t4", 1'b0, 23'h001000);
      held = out_result;
      for (int i = 0; i < 5; i++) begin
         start = 1'b1;
         in_valid = 1'b1;
         step();
         check("t4 hold out_valid", 32'(out_valid), 32'd1);
         check("t4 hold out_result", 32'(out_result), 32'(held));
         check("t4 hold in_ready", 32'(in_ready), 32'd0);
         check("t4 hold busy", 32'(busy), 32'd1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      out_ready = 1'b0;
      check("t4 ack busy", 32'(busy), 32'd0);
      step();
      check("t4 start ignored", 32'(busy), 32'd0);

      run_vec("t5gap", 1'b1, 23'h001000);
      handshake("t5gap");

      set_vec(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 3'b011, 3'b011, 3'b011, 3'b011);
      run_vec("t5pre", 1'b0, 23'h405FF4);
      handshake("t5pre");
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = 12'hFFF; in_weight = 3'b011;
         step();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      check("t5 rst busy", 32'(busy), 32'd0);
      check("t5 rst in_ready", 32'(in_ready), 32'd0);
      check("t5 rst out_valid", 32'(out_valid), 32'd0);
      check("t5 rst out_result", 32'(out_result), 32'd0);
      rst = 1'b0;
      step();
      set_vec(12'h200, 12'h200, 12'h200, 12'h200, 3'b010, 3'b010, 3'b010, 3'b010);
      run_vec("t5fresh", 1'b0, 23'h001000);
      handshake("t5fresh");

      set_vec(12'h800, 12'hA00, 12'h000, 12'h800, 3'b111, 3'b100, 3'b110, 3'b010);
      run_vec("t6", 1'b0, 23'h000000);
      handshake("t6");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
